fft_butterfly_pipe: RTL
=======================

Name: fft_butterfly_pipe

Overview:
Pipelined radix-2 decimation-in-time butterfly for the FFT datapath. It computes aout = a + b·w and bout = a − b·w on packed complex words. It generalises the combinational butterfly with parametrised data and twiddle widths, single-rounding full-precision multiply, optional per-stage divide-by-2 scaling, saturation with a sticky overflow flag, and an inverse-FFT mode that conjugates the twiddle. It sits between the sample RAM read port and the write-back port, and uses a valid/ready handshake with backpressure.

Parameters:
WIDTH, 16, bits per real/imag component of data, signed Q1.(WIDTH-1)
TW_WIDTH, 16, bits per real/imag component of twiddle, signed Q1.(TW_WIDTH-1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  a/b/twiddle/mode inputs valid
in_ready  output  1  block accepts input this cycle
a  input  2*WIDTH  {re, im}
b  input  2*WIDTH  {re, im}
twiddle  input  2*TW_WIDTH  {re, im}
scale  input  1  1 = outputs divided by 2 (sampled with the input beat)
inverse  input  1  1 = use conj(twiddle) (sampled with the input beat)
out_valid  output  1  aout/bout valid
out_ready  input  1  downstream accepts output
aout  output  2*WIDTH  {re, im} of a + b·w
bout  output  2*WIDTH  {re, im} of a − b·w
ovf  output  1  sticky saturation flag
clear_ovf  input  1  clears ovf

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on reset.
- Reset values: out_valid=0, aout=0, bout=0, ovf=0. All internal stage valids are 0. in_ready is 1 in the cycle after reset deasserts.
- Reset mid-operation: in-flight beats are discarded, and no out_valid is produced for them.
- Pipeline: 3 register stages. Latency is 3 cycles from input acceptance to out_valid when there is no stall.
  - S1 registers a, b, twiddle, scale, inverse and valid.
  - S2 registers the four full-precision products br·wr, bi·wi, br·wi, bi·wr (WIDTH+TW_WIDTH bits each), plus delayed a and flags. If inverse=1, wi is negated before multiplying (conj). Negating −2^(TW_WIDTH−1) yields +2^(TW_WIDTH−1)−1.
  - S3 registers aout, bout and out_valid.
- Handshake: adv = ~out_valid | out_ready, and in_ready = adv (combinational).
  - A transfer occurs when in_valid & in_ready.
  - When adv=0, all stages hold, so aout/bout stay stable while out_valid=1 and out_ready=0.
  - Bubbles are not compressed.
  - Full throughput: 1 beat per cycle while out_ready=1.
- Arithmetic, all signed:
  - pr = br·wr − bi·wi and pi = br·wi + bi·wr, computed at WIDTH+TW_WIDTH+1 bits with no intermediate truncation.
  - Round once to Q1.(WIDTH−1): shift right by TW_WIDTH−1 with round-half-up (add 2^(TW_WIDTH−2) before the shift).
  - Saturate the product to WIDTH bits. Saturation sets ovf. The case −1·−1 gives 0x7FFF at WIDTH=16.
  - Sums a±p are computed at WIDTH+1 bits.
  - scale=1: arithmetic shift right 1 with round-half-up (add 1 then shift). The result always fits in WIDTH bits and never sets ovf.
  - scale=0: saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. Any clipped component sets ovf.
- ovf is set in the cycle the S3 register loads a saturated value, whether that saturation came from the product or the sum.
  - ovf is cleared by clear_ovf.
  - If set and clear occur in the same cycle, set wins.

Test Plan:
- WIDTH=TW_WIDTH=16, scale=0. a=(0x2000,0), b=(0x2000,0), w=(0x7FFF,0), in_valid for 1 cycle, out_ready=1 -> out_valid exactly 3 cycles later; aout=(0x4000,0), bout=(0x0000,0); ovf=0.
- Same beat with scale=1 -> aout=(0x2000,0), bout=(0x0000,0).
- a=(0x7000,0), b=(0x7000,0), w=(0x7FFF,0), scale=0 -> aout=(0x7FFF,0), bout=(0x0001,0); ovf=1 and stays 1 until clear_ovf is pulsed, after which ovf=0.
- a=0, b=(0x8000,0), w=(0x8000,0) -> product saturates: aout=(0x7FFF,0), bout=(0x8001,0), ovf=1.
- a=0, b=(0x1000,0), w=(0,0x7FFF): inverse=0 -> aout=(0,0x1000), bout=(0,0xF000); inverse=1 -> aout=(0,0xF000), bout=(0,0x1000).
- Stream 8 beats back-to-back with out_ready toggling 1,0,0,1,... -> all 8 outputs in order with none lost or duplicated, and outputs stable while stalled. A reset asserted mid-stream -> out_valid=0 the next cycle and no stale beats appear afterwards.

Source files
------------

// File: rtl/fft_butterfly_pipe.sv
// fft_butterfly_pipe: 3-stage radix-2 DIT butterfly with rounding, scaling, saturation and valid/ready flow control
module fft_butterfly_pipe #(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*WIDTH-1:0]    a,
  input  logic [2*WIDTH-1:0]    b,
  input  logic [2*TW_WIDTH-1:0] twiddle,
  input  logic                  scale,
  input  logic                  inverse,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*WIDTH-1:0]    aout,
  output logic [2*WIDTH-1:0]    bout,
  output logic                  ovf,
  input  logic                  clear_ovf
);
  localparam int PW = WIDTH + TW_WIDTH;
  localparam int SW = PW + 1;
  localparam int RW = WIDTH + 2;
  localparam logic signed [SW-1:0] RND = SW'(1) <<< (TW_WIDTH - 2);
  localparam logic signed [RW-1:0] MAXV = RW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] MINV = -MAXV - RW'(1);
  localparam logic signed [TW_WIDTH-1:0] TMIN = {1'b1, {(TW_WIDTH-1){1'b0}}};
  localparam logic signed [TW_WIDTH-1:0] TMAX = ~TMIN;

  // Returns {clipped, value}
  function automatic logic [WIDTH:0] sat(input logic signed [RW-1:0] x);
    return x > MAXV ? {1'b1, MAXV[WIDTH-1:0]} :
           x < MINV ? {1'b1, MINV[WIDTH-1:0]} : {1'b0, x[WIDTH-1:0]};
  endfunction

  function automatic logic [WIDTH:0] fin(input logic signed [WIDTH:0] s, input logic sc);
    return sc ? {1'b0, WIDTH'((RW'(s) + RW'(1)) >>> 1)} : sat(RW'(s));
  endfunction

  logic adv;
  logic s1_v_q, s1_v_d, s1_sc_q, s1_sc_d, s1_inv_q, s1_inv_d;
  logic [2*WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [2*TW_WIDTH-1:0] s1_w_q, s1_w_d;
  logic s2_v_q, s2_v_d, s2_sc_q, s2_sc_d;
  logic [2*WIDTH-1:0] s2_a_q, s2_a_d;
  logic signed [PW-1:0] s2_rr_q, s2_rr_d, s2_ii_q, s2_ii_d, s2_ri_q, s2_ri_d, s2_ir_q, s2_ir_d;
  logic out_valid_q, out_valid_d, ovf_q, ovf_d;
  logic [2*WIDTH-1:0] aout_q, aout_d, bout_q, bout_d;
  logic signed [WIDTH-1:0] br, bi, ar, ai, qr, qi;
  logic signed [TW_WIDTH-1:0] wr, wi;
  logic signed [SW-1:0] pr, pi;
  logic [WIDTH:0] prs, pis, o0, o1, o2, o3;

  always_comb begin
    adv = ~out_valid_q | out_ready;
    s1_v_d = adv ? in_valid : s1_v_q;
    s1_a_d = adv ? a : s1_a_q;
    s1_b_d = adv ? b : s1_b_q;
    s1_w_d = adv ? twiddle : s1_w_q;
    s1_sc_d = adv ? scale : s1_sc_q;
    s1_inv_d = adv ? inverse : s1_inv_q;
    br = s1_b_q[2*WIDTH-1:WIDTH];
    bi = s1_b_q[WIDTH-1:0];
    wr = s1_w_q[2*TW_WIDTH-1:TW_WIDTH];
    wi = s1_w_q[TW_WIDTH-1:0];
    wi = s1_inv_q ? (wi == TMIN ? TMAX : -wi) : wi;
    s2_v_d = adv ? s1_v_q : s2_v_q;
    s2_a_d = adv ? s1_a_q : s2_a_q;
    s2_sc_d = adv ? s1_sc_q : s2_sc_q;
    s2_rr_d = adv ? PW'(br) * PW'(wr) : s2_rr_q;
    s2_ii_d = adv ? PW'(bi) * PW'(wi) : s2_ii_q;
    s2_ri_d = adv ? PW'(br) * PW'(wi) : s2_ri_q;
    s2_ir_d = adv ? PW'(bi) * PW'(wr) : s2_ir_q;
    ar = s2_a_q[2*WIDTH-1:WIDTH];
    ai = s2_a_q[WIDTH-1:0];
    pr = SW'(s2_rr_q) - SW'(s2_ii_q) + RND;
    pi = SW'(s2_ri_q) + SW'(s2_ir_q) + RND;
    prs = sat(RW'(pr >>> (TW_WIDTH - 1)));
    pis = sat(RW'(pi >>> (TW_WIDTH - 1)));
    qr = prs[WIDTH-1:0];
    qi = pis[WIDTH-1:0];
    o0 = fin((WIDTH+1)'(ar) + (WIDTH+1)'(qr), s2_sc_q);
    o1 = fin((WIDTH+1)'(ai) + (WIDTH+1)'(qi), s2_sc_q);
    o2 = fin((WIDTH+1)'(ar) - (WIDTH+1)'(qr), s2_sc_q);
    o3 = fin((WIDTH+1)'(ai) - (WIDTH+1)'(qi), s2_sc_q);
    out_valid_d = adv ? s2_v_q : out_valid_q;
    aout_d = (adv & s2_v_q) ? {o0[WIDTH-1:0], o1[WIDTH-1:0]} : aout_q;
    bout_d = (adv & s2_v_q) ? {o2[WIDTH-1:0], o3[WIDTH-1:0]} : bout_q;
    ovf_d = (adv & s2_v_q & (prs[WIDTH] | pis[WIDTH] | o0[WIDTH] | o1[WIDTH] | o2[WIDTH] | o3[WIDTH]))
          | (ovf_q & ~clear_ovf);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      out_valid_q <= 1'b0;
      aout_q <= '0;
      bout_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      out_valid_q <= out_valid_d;
      aout_q <= aout_d;
      bout_q <= bout_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_a_q <= s1_a_d;
    s1_b_q <= s1_b_d;
    s1_w_q <= s1_w_d;
    s1_sc_q <= s1_sc_d;
    s1_inv_q <= s1_inv_d;
    s2_a_q <= s2_a_d;
    s2_sc_q <= s2_sc_d;
    s2_rr_q <= s2_rr_d;
    s2_ii_q <= s2_ii_d;
    s2_ri_q <= s2_ri_d;
    s2_ir_q <= s2_ir_d;
  end

  assign in_ready = adv;
  assign out_valid = out_valid_q;
  assign aout = aout_q;
  assign bout = bout_q;
  assign ovf = ovf_q;
endmodule
